// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a variable-latency imem request,
// applies branch/jump redirects and feeds IF/ID with instructions or bubbles.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out,
  output logic [31:0] pc_plus4,
  output logic        if_id_write,
  output logic        flush
);

  localparam logic [1:0] S_FETCH   = 2'd0;
  localparam logic [1:0] S_HOLD    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_hold_inst;
  logic [31:0] r_stale_addr;

  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_addr;
  logic        w_inst_valid;

  assign w_redirect = jump | branch_taken;
  assign w_target   = jump ? jump_target : branch_target;

  // Outputs are gated by rst so IF/ID sees a quiet bubble stream during reset.
  assign w_inst_valid = rst & ~w_redirect &
                        (((r_state == S_FETCH) & imem_ready) | (r_state == S_HOLD));

  assign w_addr      = (r_state == S_DISCARD) ? r_stale_addr : r_pc;
  assign imem_addr   = {w_addr[31:2], 2'b00};
  assign imem_req    = rst & (r_state != S_HOLD);
  assign inst_out    = (r_state == S_HOLD) ? r_hold_inst : imem_rdata;
  assign pc_plus4    = r_pc + 32'd4;
  assign if_id_write = rst & (pc_write | w_redirect);
  assign flush       = ~w_inst_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_hold_inst  <= 32'd0;
      r_stale_addr <= 32'd0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_redirect) begin
            r_pc <= w_target;
            // Request cannot be withdrawn: wait out the orphan at its old address.
            if (!imem_ready) begin
              r_stale_addr <= r_pc;
              r_state      <= S_DISCARD;
            end
          end else if (imem_ready) begin
            if (pc_write) begin
              r_pc <= r_pc + 32'd4;
            end else begin
              r_hold_inst <= imem_rdata;
              r_state     <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (w_redirect) begin
            r_pc    <= w_target;
            r_state <= S_FETCH;
          end else if (pc_write) begin
            r_pc    <= r_pc + 32'd4;
            r_state <= S_FETCH;
          end
        end
        S_DISCARD: begin
          if (w_redirect) begin
            r_pc <= w_target;
          end else if (imem_ready) begin
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit: a reference model of the fetch rules pushes
// expected per-cycle outputs into a queue that a negedge monitor pops and checks.
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int NCYC = 3000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pc_write = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] inst_out;
  logic [31:0] pc_plus4;
  logic        if_id_write;
  logic        flush;

  if_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .pc_write(pc_write),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .inst_out(inst_out), .pc_plus4(pc_plus4),
    .if_id_write(if_id_write), .flush(flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        wr;
    logic        fl;
    logic [31:0] inst;
    logic [31:0] pp4;
    bit          valid;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int total = 0;
  int bad = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'h1111_0000 + a;
  endfunction

  function automatic logic [31:0] pick_tgt();
    logic [31:0] t;
    if ($urandom_range(0, 3) == 0) t = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFF8 : 32'hFFFF_FFFC;
    else t = 32'($urandom_range(0, 255)) << 2;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e_mon = q.pop_front();
      chk("imem_req", 32'(imem_req), 32'(e_mon.req));
      if (e_mon.req) chk("imem_addr", imem_addr, e_mon.addr);
      chk("if_id_write", 32'(if_id_write), 32'(e_mon.wr));
      chk("flush", 32'(flush), 32'(e_mon.fl));
      chk("pc_plus4", pc_plus4, e_mon.pp4);
      if (e_mon.valid) chk("inst_out", inst_out, e_mon.inst);
    end
  end

  // Reference model: PC, whether a fetched word is parked, and whether an
  // orphaned request (with its address) must still be waited out.
  logic [31:0] m_pc, m_sa;
  bit          m_held, m_stale;
  bit          p_pw, p_br, p_j, p_rdy;
  logic [31:0] p_bt, p_jt;
  // Memory environment
  bit          busy;
  int          cnt;
  logic [31:0] maddr;

  initial begin
    exp_t e;
    bit redir, calm;
    logic [31:0] tgt;
    int rst_hold;
    m_pc = RST_PC; m_sa = '0; m_held = 0; m_stale = 0;
    p_pw = 0; p_br = 0; p_j = 0; p_rdy = 0; p_bt = '0; p_jt = '0;
    busy = 0; cnt = 0; maddr = '0;
    rst_hold = 2;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      if (rst) begin
        redir = p_j | p_br;
        tgt   = p_j ? p_jt : p_bt;
        if (m_stale) begin
          if (redir) m_pc = tgt;
          else if (p_rdy) m_stale = 0;
        end else if (m_held) begin
          if (redir) begin m_pc = tgt; m_held = 0; end
          else if (p_pw) begin m_pc = m_pc + 32'd4; m_held = 0; end
        end else begin
          if (redir) begin
            if (!p_rdy) begin m_stale = 1; m_sa = m_pc; end
            m_pc = tgt;
          end else if (p_rdy) begin
            if (p_pw) m_pc = m_pc + 32'd4;
            else m_held = 1;
          end
        end
        if (busy) begin
          if (imem_ready) busy = 0;
          else cnt--;
        end
      end
      #1;
      calm = (c < 12);
      if (rst_hold > 0) begin
        rst = 1'b0; rst_hold--;
      end else if (!calm && $urandom_range(0, 99) == 0) begin
        rst = 1'b0; rst_hold = $urandom_range(0, 1);
      end else begin
        rst = 1'b1;
      end
      if (!rst) begin
        m_pc = RST_PC; m_held = 0; m_stale = 0; busy = 0;
      end
      pc_write      = calm ? 1'b1 : ($urandom_range(0, 9) >= 3);
      jump          = !calm && ($urandom_range(0, 11) == 0);
      branch_taken  = !calm && ($urandom_range(0, 7) == 0);
      jump_target   = pick_tgt();
      branch_target = pick_tgt();
      #1;
      if (rst && imem_req && !busy) begin
        busy  = 1;
        maddr = imem_addr;
        cnt   = calm ? 0 : (($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)));
      end
      imem_ready = busy && (cnt == 0);
      imem_rdata = imem_ready ? memf(maddr) : $urandom;

      redir = jump | branch_taken;
      if (!rst) begin
        e.req = 0; e.addr = '0; e.wr = 0; e.fl = 1; e.inst = '0;
        e.pp4 = RST_PC + 32'd4; e.valid = 0;
      end else begin
        e.req   = !m_held;
        e.addr  = m_stale ? m_sa : m_pc;
        e.valid = !redir && (m_held || (!m_stale && imem_ready));
        e.wr    = pc_write | redir;
        e.fl    = !e.valid;
        e.inst  = memf(m_pc);
        e.pp4   = m_pc + 32'd4;
      end
      q.push_back(e);
      p_pw = pc_write; p_br = branch_taken; p_j = jump; p_rdy = imem_ready;
      p_bt = branch_target; p_jt = jump_target;
    end
    @(negedge clk);
    @(negedge clk);
    chk("queue_drain", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the 5-stage pipeline, directly upstream of the IF/ID pipeline register. Owns the PC, drives a variable-latency instruction-memory request/ready interface and applies branch/jump redirects. Produces the instruction, PC+4, `if_id_write` and `flush` controls that IF/ID consumes. It also inserts bubbles whenever no valid instruction is available.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous reset, active-low (asserted at 0).
- `pc_write`  in  1  from hazard unit; 0 = stall fetch and hold IF/ID.
- `branch_taken`  in  1  branch resolved taken this cycle.
- `branch_target`  in  32  branch destination.
- `jump`  in  1  jump this cycle; wins over `branch_taken`.
- `jump_target`  in  32  jump destination.
- `imem_req`  out  1  instruction-memory request.
- `imem_addr`  out  32  request address, word-aligned.
- `imem_ready`  in  1  data valid / request complete this cycle.
- `imem_rdata`  in  32  instruction word, valid when `imem_ready`.
- `inst_out`  out  32  instruction to IF/ID `inInst`.
- `pc_plus4`  out  32  address of `inst_out` + 4, to IF/ID `inpc`.
- `if_id_write`  out  1  IF/ID write enable.
- `flush`  out  1  IF/ID flush (bubble insert).

## Operation
- Registers: `pc`, `state`, `hold_inst`, `stale_addr`. Reset (`rst`=0): `pc`=RESET_PC, `state`=FETCH, `hold_inst`=0, `stale_addr`=0.
- `redirect` = `jump` | `branch_taken`; `target` = `jump` ? `jump_target` : `branch_target`.
- States:
  - FETCH: `imem_req`=1, `imem_addr`=`pc`.
  - HOLD: `imem_req`=0, instruction held in `hold_inst`.
  - DISCARD: `imem_req`=1, `imem_addr`=`stale_addr`. Waits out an orphaned request.
- Transitions, in priority order:
  - FETCH, `redirect`: `pc`<=`target`. If `imem_ready` stay FETCH (data dropped). Else `stale_addr`<=`pc` and go DISCARD.
  - FETCH, `imem_ready`, `pc_write`=1: instruction delivered, `pc`<=`pc`+4, stay FETCH.
  - FETCH, `imem_ready`, `pc_write`=0: `hold_inst`<=`imem_rdata`, go HOLD; `pc` unchanged.
  - FETCH, `imem_ready`=0: wait.
  - HOLD, `redirect`: `pc`<=`target`, go FETCH, held instruction dropped.
  - HOLD, `pc_write`=1: instruction delivered, `pc`<=`pc`+4, go FETCH.
  - DISCARD, `redirect`: `pc`<=`target` (latest wins), remain DISCARD.
  - DISCARD, `imem_ready`: data dropped, go FETCH.
- Output rules:
  - `inst_valid` = (FETCH & `imem_ready` & !`redirect`) | (HOLD & !`redirect`).
  - `inst_out` = HOLD ? `hold_inst` : `imem_rdata`.
  - `pc_plus4` = `pc` + 4 (modulo 2^32, wraps 32'hFFFF_FFFC -> 0).
  - `if_id_write` = `pc_write` | `redirect`.
  - `flush` = !`inst_valid`. IF/ID loads a bubble whenever it writes without a valid instruction.
- Precedence: `redirect` overrides `pc_write`=0. A redirect always writes a bubble into IF/ID.
- Memory protocol: once asserted, `imem_req`/`imem_addr` stay stable until `imem_ready`. A request is never withdrawn, hence DISCARD.

## Timing
- All outputs are combinational from state and inputs. No output is registered beyond `pc`/`hold_inst`.
- Zero-wait memory (`imem_ready` same cycle as request): one instruction per cycle, fetch-to-IF/ID latency 0 cycles (captured on the same edge).
- N wait cycles: N bubbles written into IF/ID (if `pc_write`=1), then the instruction.
- Redirect penalty: redirect cycle writes a bubble; new target requested next cycle. If a request was outstanding, add the remaining stale latency.
- Simultaneous `imem_ready` + `redirect` in FETCH: data dropped, no DISCARD entry.
- Reset mid-operation: immediate return to reset values; an in-flight memory request is abandoned. The memory model must tolerate this.
- During reset: `imem_req`=0, `if_id_write`=0, `flush`=1, `pc_plus4`=RESET_PC+4.

## Test plan
- Reset release, zero-wait memory returning 32'h1111_0000+addr: IF/ID sees pc_plus4 4, 8, 12 on consecutive cycles, `flush`=0.
- `imem_ready` delayed 2 cycles at pc=8: two cycles `if_id_write`=1/`flush`=1, then inst with pc_plus4=12.
- `pc_write`=0 for 3 cycles as instruction at pc=16 arrives: HOLD entered, `if_id_write`=0, `imem_req`=0. On release, `inst_out`=held word, pc_plus4=20, next request addr 20.
- `branch_taken`=1, `branch_target`=32'h40 while request for pc=24 outstanding (ready 2 cycles later): `flush`=1, DISCARD keeps `imem_addr`=24 until ready, stale data dropped, next request addr 0x40.
- `jump`=1 (target 0x80) and `branch_taken`=1 (target 0x40) together, plus `pc_write`=0: `pc`->0x80, `if_id_write`=1, `flush`=1.
- `rst`=0 asserted in HOLD: `pc`=RESET_PC, state FETCH, `hold_inst`=0 asynchronously, before the next clock edge.
